// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between four requesters.
// Holds the grant until mem_done, with a watchdog that aborts stuck transactions.
module mem_port_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       mem_done,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       mem_start,
  output logic       busy,
  output logic       timeout_err,
  output logic [1:0] err_id,
  output logic       state_dbg,
  output logic [1:0] last_dbg
);

  // Handshake: mem_start is a one-cycle strobe on the first BUSY cycle; mem_done is a
  // one-cycle pulse that is only honoured while BUSY (ignored in IDLE).
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [0:0]       state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       sel_q, sel_d;
  logic             mem_start_q, mem_start_d;
  logic             busy_q, busy_d;
  logic             timeout_err_q, timeout_err_d;
  logic [1:0]       err_id_q, err_id_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [1:0] winner;
  logic [1:0] idx;
  logic       found;

  // Search starts just after the last served requester, ending on it.
  always_comb begin
    winner = last_q;
    idx    = last_q;
    found  = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_q + 2'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    sel_d         = sel_q;
    mem_start_d   = 1'b0;
    busy_d        = busy_q;
    timeout_err_d = 1'b0;
    err_id_d      = err_id_q;
    last_d        = last_q;
    count_d       = count_q;
    case (state_q)
      IDLE: begin
        grant_d = 4'b0000;
        busy_d  = 1'b0;
        if (found) begin
          state_d     = BUSY;
          grant_d     = 4'b0001 << winner;
          sel_d       = winner;
          busy_d      = 1'b1;
          mem_start_d = 1'b1;
          count_d     = '0;
        end
      end
      BUSY: begin
        if (mem_done) begin
          state_d = IDLE;
          grant_d = 4'b0000;
          busy_d  = 1'b0;
          last_d  = sel_q;
        end else if (count_q == COUNT_LAST) begin
          state_d       = IDLE;
          grant_d       = 4'b0000;
          busy_d        = 1'b0;
          timeout_err_d = 1'b1;
          err_id_d      = sel_q;
          last_d        = sel_q;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= 4'b0000;
      sel_q         <= 2'd0;
      mem_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      err_id_q      <= 2'd0;
      last_q        <= 2'd3;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      sel_q         <= sel_d;
      mem_start_q   <= mem_start_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      err_id_q      <= err_id_d;
      last_q        <= last_d;
      count_q       <= count_d;
    end
  end

  assign grant       = grant_q;
  assign sel         = sel_q;
  assign mem_start   = mem_start_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign err_id      = err_id_q;
  assign state_dbg   = state_q[0];
  assign last_dbg    = last_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 16;

  logic       clock;
  logic       reset;
  logic [3:0] req;
  logic       mem_done;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       mem_start;
  logic       busy;
  logic       timeout_err;
  logic [1:0] err_id;
  logic       state_dbg;
  logic [1:0] last_dbg;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .req(req), .mem_done(mem_done),
    .grant(grant), .sel(sel), .mem_start(mem_start), .busy(busy),
    .timeout_err(timeout_err), .err_id(err_id),
    .state_dbg(state_dbg), .last_dbg(last_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model: who owns the port, for how many cycles, who went last
  logic       model_ok = 1'b0;
  logic       m_busy;
  int         m_owner, m_last, m_age;
  logic [3:0] exp_grant;
  logic [1:0] exp_sel, exp_errid;
  logic       exp_start, exp_terr;
  logic [1:0] exp_q[$];

  function automatic int pick_winner(input int last, input logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      model_ok  = 1'b1;
      m_busy    = 1'b0;
      m_owner   = 0;
      m_last    = 3;
      m_age     = 0;
      exp_grant = 4'b0;
      exp_sel   = 2'd0;
      exp_errid = 2'd0;
      exp_start = 1'b0;
      exp_terr  = 1'b0;
      exp_q.delete();
    end else if (model_ok) begin
      exp_start = 1'b0;
      exp_terr  = 1'b0;
      if (!m_busy) begin
        exp_grant = 4'b0;
        if (req != 4'b0) begin
          m_owner   = pick_winner(m_last, req);
          m_busy    = 1'b1;
          m_age     = 1;
          exp_grant = 4'(1 << m_owner);
          exp_sel   = 2'(m_owner);
          exp_start = 1'b1;
          exp_q.push_back(2'(m_owner));
        end
      end else if (mem_done) begin
        m_busy    = 1'b0;
        exp_grant = 4'b0;
        m_last    = m_owner;
      end else if (m_age == TIMEOUT) begin
        m_busy    = 1'b0;
        exp_grant = 4'b0;
        exp_terr  = 1'b1;
        exp_errid = 2'(m_owner);
        m_last    = m_owner;
      end else begin
        m_age++;
      end
    end
  end

  // per-cycle compare plus scoreboard of granted requesters
  logic [1:0] popped;
  always @(negedge clock) begin
    if (model_ok) begin
      total++;
      if ({grant, sel, mem_start, busy, timeout_err, err_id, state_dbg, last_dbg} !==
          {exp_grant, exp_sel, exp_start, m_busy, exp_terr, exp_errid, m_busy, 2'(m_last)}) begin
        bad++;
        $display("FAIL cycle_cmp t=%0t got g=%b s=%0d st=%b b=%b te=%b id=%0d fsm=%b last=%0d exp g=%b s=%0d st=%b b=%b te=%b id=%0d last=%0d",
                 $time, grant, sel, mem_start, busy, timeout_err, err_id, state_dbg, last_dbg,
                 exp_grant, exp_sel, exp_start, m_busy, exp_terr, exp_errid, m_last);
      end
      if (mem_start === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_start t=%0t got start with sel=%0d exp no grant pending", $time, sel);
        end else begin
          popped = exp_q.pop_front();
          if (sel !== popped) begin
            bad++;
            $display("FAIL sb_sel t=%0t got %0d exp %0d", $time, sel, popped);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 4'b0; mem_done = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic wait_start(input string name);
    int n;
    n = 0;
    while (mem_start !== 1'b1 && n < 20) begin
      step(1);
      n++;
    end
    if (mem_start !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s got no mem_start exp mem_start within 20 cycles", name);
    end
  endtask

  task automatic pulse_done();
    mem_done = 1'b1;
    step(1);
    mem_done = 1'b0;
  endtask

  logic [3:0] rot_exp[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int         nbusy;
  int         done_div;

  initial begin
    reset = 1'b1; req = 4'b0; mem_done = 1'b0;
    do_reset();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_last", 32'(last_dbg), 32'h3);
    check("rst_errid", 32'(err_id), 32'h0);

    // single requester, done in third busy cycle
    req = 4'b0001;
    step(1);
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_start", 32'(mem_start), 32'h1);
    req = 4'b0000;
    step(1);
    check("t1_start_drop", 32'(mem_start), 32'h0);
    step(1);
    check("t1_busy3", 32'(busy), 32'h1);
    pulse_done();
    check("t1_release", 32'({grant, busy}), 32'h0);
    check("t1_last", 32'(last_dbg), 32'h0);

    // strict rotation with all four requesting
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_start("rot_wait");
      check("rot_grant", 32'(grant), 32'(rot_exp[i]));
      step(1);
      pulse_done();
      check("rot_dead", 32'(busy), 32'h0);
      step(1);
    end

    // after requester 2, req=0101 goes to requester 0
    do_reset();
    req = 4'b0100;
    wait_start("rr2_wait");
    req = 4'b0101;
    pulse_done();
    step(1);
    check("rr2_next", 32'(grant), 32'h1);
    pulse_done();
    req = 4'b0000;

    // grant held although request dropped
    do_reset();
    req = 4'b0010;
    wait_start("hold_wait");
    req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("hold_grant", 32'(grant), 32'h2);
    end
    pulse_done();
    check("hold_release", 32'(grant), 32'h0);

    // watchdog on requester 3
    do_reset();
    req = 4'b1000;
    wait_start("to_wait");
    req = 4'b0000;
    nbusy = 0;
    while (busy === 1'b1 && nbusy < 40) begin
      nbusy++;
      step(1);
    end
    check("to_busy_cycles", 32'(nbusy), 32'd16);
    check("to_err", 32'(timeout_err), 32'h1);
    check("to_errid", 32'(err_id), 32'h3);
    check("to_grant", 32'(grant), 32'h0);
    step(1);
    check("to_pulse", 32'(timeout_err), 32'h0);
    pulse_done();
    check("to_late_done", 32'({busy, err_id}), 32'h3);

    // done on the last watchdog cycle wins
    do_reset();
    req = 4'b0001;
    wait_start("edge_wait");
    req = 4'b0000;
    step(TIMEOUT - 1);
    pulse_done();
    check("edge_no_err", 32'(timeout_err), 32'h0);
    check("edge_release", 32'(busy), 32'h0);

    // reset in the middle of a transaction
    req = 4'b0010;
    wait_start("mrst_wait");
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    req = 4'b0000;
    check("mrst_outs", 32'({grant, sel, mem_start, busy, timeout_err, err_id}), 32'h0);
    check("mrst_last", 32'(last_dbg), 32'h3);
    pulse_done();
    check("mrst_done_ignored", 32'(busy), 32'h0);

    // random traffic: chatty memory first, then a sluggish one to hit the watchdog
    for (int c = 0; c < 800; c++) begin
      done_div = (c < 400) ? 5 : 30;
      req      = 4'($urandom_range(0, 15));
      mem_done = ($urandom_range(0, done_div) == 0);
      reset    = ($urandom_range(0, 199) == 0);
      step(1);
    end
    reset = 1'b0; req = 4'b0; mem_done = 1'b0;
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
